// File: rtl/eject_fifo_pkg.sv
// Shared flit definitions: field layout and local destination codes for the
// arbiter and the eject FIFO.
package eject_fifo_pkg;

  localparam int unsigned FLIT_W    = 10;
  localparam int unsigned VALID_BIT = 9;
  localparam int unsigned DEST_HI   = 8;
  localparam int unsigned DEST_LO   = 6;
  localparam int unsigned DEST_W    = DEST_HI - DEST_LO + 1;
  localparam int unsigned OUT_W     = FLIT_W - 1;

  localparam logic [DEST_W-1:0] DEST_LOCAL0 = 3'b000;
  localparam logic [DEST_W-1:0] DEST_LOCAL1 = 3'b001;

  function automatic logic is_local(input logic valid, input logic [DEST_W-1:0] dest);
    return valid && ((dest == DEST_LOCAL0) || (dest == DEST_LOCAL1));
  endfunction

endpackage

// File: rtl/eject_fifo_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc && !(&value_q)) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/eject_fifo.sv
// Eject FIFO: buffers local-destination flits for the core, first-word-fall-through,
// counting flits dropped while full.
module eject_fifo
  import eject_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_flit,
  output logic [OUT_W-1:0]         out_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic flit_local;
  logic push;
  logic pop;
  logic drop;

  assign flit_local = is_local(in_flit[VALID_BIT], in_flit[DEST_HI:DEST_LO]);
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot the write pointer already points at.
  assign push       = flit_local && ((count_q < DepthC) || pop);
  assign drop       = flit_local && !push;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_flit[OUT_W-1:0];
      end
    end
  end

  sat_counter #(
    .WIDTH (DROP_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .value (drop_cnt)
  );

  assign out_flit    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign full        = (count_q == DepthC);
  assign almost_full = (count_q >= DepthC - CntW'(1));

endmodule

// File: tb/tb_eject_fifo.sv
// Bench for eject_fifo: directed vector table, multi-cycle corner sequences and
// randomized traffic against a queue-based reference model.
module tb_eject_fifo;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] in_flit = '0;
  logic [8:0] out_flit;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       full;
  logic       almost_full;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  eject_fifo #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  // Reference model: ordered queue of stored flits plus a saturating drop tally.
  logic [8:0] mq[$];
  int         mdrop = 0;

  typedef struct {
    logic [9:0] flit;
    logic       rdy;
    int         cnt;
    logic       vld;
    logic [8:0] out;
    logic       fl;
    logic       af;
    int         drop;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_loc(input logic [9:0] f);
    return f[9] && (f[8:6] == 3'd0 || f[8:6] == 3'd1);
  endfunction

  task automatic model_cycle(input logic [9:0] f, input logic r);
    bit popped;
    popped = (mq.size() > 0) && r;
    if (popped) void'(mq.pop_front());
    if (is_loc(f)) begin
      if (mq.size() < DEPTH) mq.push_back(f[8:0]);
      else if (mdrop < DMAX) mdrop++;
    end
  endtask

  task automatic step(input logic [9:0] f, input logic r);
    in_flit   = f;
    out_ready = r;
    model_cycle(f, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, int'(count), mq.size());
    chk({tag, ".valid"}, int'(out_valid), int'(mq.size() != 0));
    chk({tag, ".full"}, int'(full), int'(mq.size() == DEPTH));
    chk({tag, ".afull"}, int'(almost_full), int'(mq.size() >= DEPTH - 1));
    chk({tag, ".drop"}, int'(drop_cnt), mdrop);
    if (mq.size() != 0) chk({tag, ".out"}, int'(out_flit), int'(mq[0]));
  endtask

  task automatic do_reset();
    in_flit   = '0;
    out_ready = 1'b0;
    #3 rst = 1'b1;
    mq.delete();
    mdrop = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // flit, rdy, cnt, vld, out, full, afull, drop
    vecs[0]  = '{10'h205, 1'b0, 1, 1'b1, 9'h005, 1'b0, 1'b0, 0};
    vecs[1]  = '{10'h243, 1'b0, 2, 1'b1, 9'h005, 1'b0, 1'b0, 0};
    vecs[2]  = '{10'h000, 1'b1, 1, 1'b1, 9'h043, 1'b0, 1'b0, 0};
    vecs[3]  = '{10'h000, 1'b1, 0, 1'b0, 9'h000, 1'b0, 1'b0, 0};
    vecs[4]  = '{10'h3C1, 1'b0, 0, 1'b0, 9'h000, 1'b0, 1'b0, 0};
    vecs[5]  = '{10'h001, 1'b1, 0, 1'b0, 9'h000, 1'b0, 1'b0, 0};
    vecs[6]  = '{10'h201, 1'b0, 1, 1'b1, 9'h001, 1'b0, 1'b0, 0};
    vecs[7]  = '{10'h242, 1'b0, 2, 1'b1, 9'h001, 1'b0, 1'b0, 0};
    vecs[8]  = '{10'h203, 1'b0, 3, 1'b1, 9'h001, 1'b0, 1'b1, 0};
    vecs[9]  = '{10'h244, 1'b0, 4, 1'b1, 9'h001, 1'b1, 1'b1, 0};
    vecs[10] = '{10'h205, 1'b0, 4, 1'b1, 9'h001, 1'b1, 1'b1, 1};
    vecs[11] = '{10'h246, 1'b1, 4, 1'b1, 9'h042, 1'b1, 1'b1, 1};
    vecs[12] = '{10'h000, 1'b1, 3, 1'b1, 9'h003, 1'b0, 1'b1, 1};
    vecs[13] = '{10'h000, 1'b1, 2, 1'b1, 9'h044, 1'b0, 1'b0, 1};
    vecs[14] = '{10'h000, 1'b1, 1, 1'b1, 9'h046, 1'b0, 1'b0, 1};
    vecs[15] = '{10'h000, 1'b1, 0, 1'b0, 9'h000, 1'b0, 1'b0, 1};

    do_reset();
    chk("rst.count", int'(count), 0);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.out", int'(out_flit), 0);
    chk("rst.full", int'(full), 0);
    chk("rst.afull", int'(almost_full), 0);
    chk("rst.drop", int'(drop_cnt), 0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].flit, vecs[i].rdy);
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(vecs[i].vld));
      if (vecs[i].vld) chk($sformatf("vec%0d.out", i), int'(out_flit), int'(vecs[i].out));
      chk($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].fl));
      chk($sformatf("vec%0d.afull", i), int'(almost_full), int'(vecs[i].af));
      chk($sformatf("vec%0d.drop", i), int'(drop_cnt), vecs[i].drop);
    end

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < DEPTH + 300; i++) step(10'h200 | 10'(i & 63), 1'b0);
    chk("sat.drop", int'(drop_cnt), 255);
    chk("sat.count", int'(count), DEPTH);
    chk("sat.out", int'(out_flit), 9'h000);
    step(10'h27F, 1'b0);
    chk("sat.hold", int'(drop_cnt), 255);

    // Asynchronous reset mid-cycle with three flits held.
    do_reset();
    step(10'h211, 1'b0);
    step(10'h252, 1'b0);
    step(10'h213, 1'b0);
    chk("arst.pre_count", int'(count), 3);
    #1 rst = 1'b1;
    #1;
    chk("arst.valid", int'(out_valid), 0);
    chk("arst.count", int'(count), 0);
    chk("arst.drop", int'(drop_cnt), 0);
    chk("arst.out", int'(out_flit), 0);
    mq.delete();
    mdrop = 0;
    #1 rst = 1'b0;
    step(10'h22B, 1'b0);
    chk("arst.count1", int'(count), 1);
    chk("arst.first", int'(out_flit), 9'h02B);
    check_model("arst.model");

    // Randomized traffic with varying backpressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] f;
      logic       r;
      int         rp;
      rp = (i / 500) % 3 == 0 ? 20 : ((i / 500) % 3 == 1 ? 80 : 50);
      f  = 10'($urandom);
      if ($urandom_range(0, 3) != 0) f[8:6] = 3'($urandom_range(0, 1));
      r  = ($urandom_range(0, 99) < rp);
      step(f, r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/eject_fifo.md
EJECT_FIFO -- requirements
Module: eject_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of flit entries in the FIFO; SHALL be a power of two, at least 2.
REQ-002 Parameter DROP_W, default 8, width of the drop counter.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port in_flit  input  10  flit from the arbiter's local output; bit 9 = valid, bits 8:6 = destination field, bits 5:0 = payload.
REQ-006 Port out_flit  output  9  head flit delivered to the local core: destination field in bits 8:6, payload in bits 5:0, valid bit stripped.
REQ-007 Port out_valid  output  1  high while the FIFO holds at least one flit.
REQ-008 Port out_ready  input  1  the core accepts the head flit in any cycle where out_valid and out_ready are both high.
REQ-009 Port full  output  1  high when the FIFO count equals DEPTH.
REQ-010 Port almost_full  output  1  high when the FIFO count is DEPTH-1 or more.
REQ-011 Port count  output  clog2(DEPTH)+1  number of flits currently held.
REQ-012 Port drop_cnt  output  DROP_W  number of local flits dropped because the FIFO was full; saturating.

Function
REQ-013 An incoming flit is eligible (a "local flit") only when in_flit[9]=1 and in_flit[8:6] is 3'b000 or 3'b001; every other in_flit is ignored.
REQ-014 A pop occurs when out_valid=1 and out_ready=1.
REQ-015 A push occurs when a local flit arrives and either count<DEPTH or a pop occurs in the same cycle.
REQ-016 When full=1 and a pop occurs, a simultaneous local flit SHALL be written into the slot being freed, and count SHALL stay at DEPTH.
REQ-017 When a local flit arrives, count=DEPTH and no pop occurs, the flit SHALL be discarded and drop_cnt SHALL increment by 1.
REQ-018 drop_cnt SHALL saturate at 2^DROP_W-1 and never wrap back to zero.
REQ-019 count next = count + push - pop; no other updates are allowed.
REQ-020 The write pointer and read pointer SHALL each advance by 1 on a push and a pop respectively, wrapping modulo DEPTH.
REQ-021 Storage is first-word-fall-through: out_flit = mem[rd_ptr][8:0] and out_valid = (count!=0).
REQ-022 A flit pushed at edge N SHALL appear on out_flit/out_valid after edge N, i.e. one cycle of latency.
REQ-023 A pop with an empty FIFO is impossible because out_valid=0; out_ready while empty SHALL have no effect.
REQ-024 Flits SHALL leave the FIFO in the same order they were pushed; no reordering and no duplication.
REQ-025 full, almost_full and count are decoded from registered state and SHALL be glitch-free functions of count only.

Reset
REQ-026 While rst=1, the following SHALL be held at zero: count, rd_ptr, wr_ptr, drop_cnt and all mem entries; out_valid=0, out_flit=0, full=0, almost_full=0.
REQ-027 Asserting rst in the middle of traffic SHALL discard all stored flits immediately, with no further pops and no drop_cnt increment.
REQ-028 The first push SHALL be accepted at the first rising clk edge after rst is deasserted.

Structure
REQ-029 A shared flit package SHALL hold FLIT_W=10, VALID_BIT=9, the DEST field range 8:6, and the local destination codes 3'b000 and 3'b001; the arbiter and this block SHALL both use it.
REQ-030 The saturating drop counter SHALL be a sub-module named sat_counter, parameterised by width; all other logic stays flat.

Verification
REQ-031 Reset, then local flits 10'h205, 10'h243 on consecutive cycles with out_ready=0 -> count=2 and out_flit=9'h005; raise out_ready -> out_flit 9'h005 then 9'h043, then out_valid=0.
REQ-032 Non-local flit 10'h3C1 (dest 3'b111) and invalid flit 10'h001 -> count stays 0 and drop_cnt stays 0.
REQ-033 Push 5 local flits with DEPTH=4 and out_ready=0 -> full=1, count=4, drop_cnt=1, and the 5th flit never appears on out_flit.
REQ-034 With the FIFO full, pop and push a local flit in the same cycle -> count stays 4, no drop, and the new flit emerges last in order.
REQ-035 Force 300 drops with DROP_W=8 -> drop_cnt=255 and holds there.
REQ-036 With 3 flits stored, assert rst for a partial cycle asynchronously -> out_valid=0 and count=0 immediately; the next local flit after release is output first.
